// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin sharing of the register file write port between two writeback requesters
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic [NUM_REGS-1:0]   wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  fwd_valid,
  output logic [ADDR_WIDTH-1:0] fwd_addr,
  output logic                  grant_id
);
  logic                  prio;
  logic                  grant;
  logic                  gid;
  logic                  keep;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_data;
  always_comb begin
    req0_ready = rst_n && !stall && req0_valid && (!req1_valid || !prio);
    req1_ready = rst_n && !stall && req1_valid && (!req0_valid || prio);
    grant      = req0_ready || req1_ready;
    gid        = req1_ready;
    g_addr     = gid ? req1_addr : req0_addr;
    g_data     = gid ? req1_data : req0_data;
    // out-of-range and hardwired-zero targets complete the handshake but never write
    keep       = (32'(g_addr) < NUM_REGS) && !(ZERO_REG != 0 && g_addr == '0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio      <= 1'b0;
      wr_en     <= '0;
      wr_data   <= '0;
      fwd_valid <= 1'b0;
      fwd_addr  <= '0;
      grant_id  <= 1'b0;
    end else begin
      wr_en     <= (grant && keep) ? (NUM_REGS'(1) << g_addr) : '0;
      fwd_valid <= grant && keep;
      if (grant) begin
        prio     <= ~gid;
        wr_data  <= g_data;
        fwd_addr <= g_addr;
        grant_id <= gid;
      end
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed vectors with hand-computed expectations for the write arbiter
module tb_regfile_write_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic [31:0] wr_en;
  logic [31:0] wr_data;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic        grant_id;
  logic [31:0] regs [32];
  int n_chk = 0;
  int n_fail = 0;

  regfile_write_arbiter dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .wr_en(wr_en), .wr_data(wr_data), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    for (int i = 0; i < 32; i++) if (wr_en[i]) regs[i] <= wr_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0, c1;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    rst_n = 1'b0; stall = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    tick(); tick();
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_fwd_valid", fwd_valid, 0);
    check("rst_fwd_addr", fwd_addr, 0);
    check("rst_grant_id", grant_id, 0);
    rst_n = 1'b1;

    // single requester on port 0
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    #1;
    check("single_ready0", req0_ready, 1);
    check("single_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    check("single_wr_en", wr_en, 32'h0000_0020);
    check("single_wr_data", wr_data, 32'hDEADBEEF);
    check("single_fwd_valid", fwd_valid, 1);
    check("single_fwd_addr", fwd_addr, 5);
    check("single_grant_id", grant_id, 0);
    tick();
    check("single_wr_en_clr", wr_en, 0);
    check("single_fwd_clr", fwd_valid, 0);
    check("single_reg5", regs[5], 32'hDEADBEEF);

    // port 1 to addr 9, then reset before the capture edge
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h9999_0009;
    #1;
    check("r9_ready1", req1_ready, 1);
    tick();
    check("r9_wr_en", wr_en, 32'h0000_0200);
    check("r9_grant_id", grant_id, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_wr_en", wr_en, 0);
    check("midrst_fwd_valid", fwd_valid, 0);
    check("midrst_grant_id", grant_id, 0);
    check("midrst_ready1", req1_ready, 0);
    tick();
    check("midrst_reg9", regs[9], 0);
    req1_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("release_no_write", wr_en, 0);

    // contention right after reset: 0,1,0,1
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h11;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h22;
    c0 = 0; c1 = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("cont%0d_ready0", i), req0_ready, (i % 2 == 0));
      check($sformatf("cont%0d_ready1", i), req1_ready, (i % 2 == 1));
      c0 += int'(req0_ready); c1 += int'(req1_ready);
      tick();
      check($sformatf("cont%0d_wr_en", i), wr_en, (i % 2) ? 32'h10 : 32'h8);
      check($sformatf("cont%0d_wr_data", i), wr_data, (i % 2) ? 32'h22 : 32'h11);
      check($sformatf("cont%0d_grant_id", i), grant_id, i % 2);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("cont_pulses0", c0, 2);
    check("cont_pulses1", c1, 2);

    // write to register 0 is handshaken but discarded
    req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'h55;
    #1;
    check("zero_ready0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    check("zero_wr_en", wr_en, 0);
    check("zero_fwd_valid", fwd_valid, 0);
    check("zero_grant_id", grant_id, 0);

    // stall with both valid: nothing granted, prio stays at 1
    stall = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'hAAAA;
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'hBBBB;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("stall%0d_ready0", i), req0_ready, 0);
      check($sformatf("stall%0d_ready1", i), req1_ready, 0);
      tick();
      check($sformatf("stall%0d_wr_en", i), wr_en, 0);
    end
    stall = 1'b0;

    // same-address collision with prio=1
    #1;
    check("coll_ready1", req1_ready, 1);
    check("coll_ready0", req0_ready, 0);
    tick();
    req1_valid = 1'b0;
    check("coll_first_data", wr_data, 32'hBBBB);
    check("coll_first_wr_en", wr_en, 32'h80);
    check("coll_first_gid", grant_id, 1);
    #1;
    check("coll_second_ready0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    check("coll_second_data", wr_data, 32'hAAAA);
    check("coll_second_wr_en", wr_en, 32'h80);
    check("coll_second_gid", grant_id, 0);
    tick();
    check("coll_idle", wr_en, 0);
    check("coll_reg7", regs[7], 32'hAAAA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 32×32-bit register file between two writeback requesters: port 0 (ALU writeback) and port 1 (memory-load writeback). Each requester uses a valid/ready handshake. The arbiter picks one accepted write per cycle by round-robin. It drives registered one-hot per-register write enables and write data straight into the register array. It also exposes the in-flight write for read-side forwarding.

## Interface
Parameters:
- DATA_WIDTH, 32, width of register data
- ADDR_WIDTH, 5, register address width
- NUM_REGS, 32, number of registers; write enable vector width
- ZERO_REG, 1, when 1, writes to address 0 are accepted but discarded

Ports:
- clk  input  1  single clock; all state updates on posedge
- rst_n  input  1  asynchronous, active-low reset
- stall  input  1  when high, no request is granted this cycle
- req0_valid  input  1  port 0 has a write pending
- req0_addr  input  ADDR_WIDTH  port 0 destination register
- req0_data  input  DATA_WIDTH  port 0 write data
- req0_ready  output  1  port 0 write accepted this cycle (combinational)
- req1_valid / req1_addr / req1_data / req1_ready  same as port 0, for port 1
- wr_en  output  NUM_REGS  one-hot register write enables (registered)
- wr_data  output  DATA_WIDTH  data for the enabled register (registered)
- fwd_valid  output  1  a write is presented on wr_en this cycle
- fwd_addr  output  ADDR_WIDTH  address of that write
- grant_id  output  1  port that won the most recent grant

## Operation
- Transfer on port k occurs when reqk_valid && reqk_ready at a posedge.
- Arbitration state is a 1-bit round-robin pointer `prio`, meaning the port that wins a tie. Reset value is 0.
  - Only one port valid and stall=0: that port gets ready=1.
  - Both valid and stall=0: port `prio` gets ready=1; the other gets ready=0.
  - After any grant, `prio` becomes the port that was not granted. With no grant, `prio` holds.
  - With stall=1, both ready=0 and `prio` holds.
- Output stage, updated on every posedge:
  - On a grant, wr_data ← granted data and fwd_addr ← granted addr.
  - wr_en ← one-hot decode of addr.
  - fwd_valid ← 1, and grant_id ← granted port.
  - With no grant: wr_en ← 0 and fwd_valid ← 0. wr_data, fwd_addr and grant_id hold.
- Discarded writes (handshake completes, `prio` rotates, grant_id updates, but wr_en ← 0 and fwd_valid ← 0):
  - addr ≥ NUM_REGS.
  - addr == 0 when ZERO_REG=1.
- Both ports targeting the same address in the same cycle is not an error. The writes are serialized: the grant winner goes first, and the other port's write lands one cycle later and is final.
- The requester must hold valid, addr and data stable until ready. The arbiter does not check this.
- wr_en is always zero or one-hot. It is never multi-hot.

## Timing
- Reset (rst_n low, asynchronous):
  - wr_en=0, wr_data=0, fwd_valid=0, fwd_addr=0, grant_id=0, prio=0.
  - req0_ready and req1_ready are forced to 0 while rst_n is low.
- Latency: a handshake at edge N puts wr_en/wr_data valid during cycle N→N+1. The register captures at edge N+1, two edges after the request is presented.
- Throughput: one write per cycle. Under continuous dual requests, grants alternate 0,1,0,1… Maximum wait for a valid port is 1 cycle, absent stall.
- ready depends combinationally on valid, stall and `prio` only. It never depends on ready from the same port.
- Reset asserted mid-operation clears any pending output write: wr_en=0 immediately, and the write is lost. The first grant after release goes to port 0 if both are valid.
- Deasserting rst_n does not itself produce a write.

## Test plan
- Reset mid-write: grant port 1 at addr 9, assert rst_n=0 before the capture edge. Required: wr_en=0 immediately, prio=0, and the next dual request grants port 0 first.
- Single requester: req0 valid, addr=5, data=0xDEADBEEF. Required: req0_ready=1 the same cycle. Next cycle wr_en=32'h0000_0020, wr_data=0xDEADBEEF, fwd_valid=1, fwd_addr=5. Following cycle wr_en=0.
- Contention after reset: both valid for 4 cycles, addr0=3/data 0x11, addr1=4/data 0x22. Required: grants in order 0,1,0,1 and wr_en alternates 0x8, 0x10. Each port sees exactly two ready pulses.
- Same-address collision: both write addr 7 with 0xAAAA and 0xBBBB, prio=1. Required: the 0xBBBB write is presented first and 0xAAAA the next cycle. The register ends at 0xAAAA.
- Zero-register and stall: a write to addr 0 completes its handshake, and wr_en stays 0 and fwd_valid 0. With stall=1 for 3 cycles and both valid, both ready stay 0 and prio is unchanged.
